pe_array: RTL and testbench
===========================

// Module: pe_array
// PURPOSE
//   MAC_NUM parallel signed multiply-accumulate PEs sharing one broadcast weight.
//   Each PE n accumulates PE_act_in[n]*PE_wet_in into its own BW_ACCU accumulator.
//   On a clear request the accumulator is requantised to BW_ACT and presented on PE_result_out[n].
//   Compute core of the matrix-multiply datapath: one output column chunk per accumulate/clear pass.
// PARAMETERS
//   MAC_NUM  10  number of PEs (spatial lanes)
//   BW_ACT   8   activation and result width, signed
//   BW_WET   8   weight width, signed
//   BW_ACCU  32  accumulator width, signed
// PORTS
//   clk               in   1                       single clock, all state updates on rising edge
//   reset_n           in   1                       synchronous, active-high reset (asserted when 1; name kept per codebase)
//   PE_mac_enable     in   1                       1 = accumulate this cycle
//   PE_clear_acc      in   1                       1 = end of pass: capture, then clear accumulators
//   PE_act_in         in   [MAC_NUM] x BW_ACT      signed activation per lane (unpacked array)
//   PE_wet_in         in   BW_WET                  signed weight broadcast to all lanes
//   PE_res_shift_num  in   8                       requantisation right-shift amount
//   PE_result_out     out  [MAC_NUM] x BW_ACT      signed requantised result per lane (unpacked array)
// BEHAVIOUR
//   - Reset (reset_n==1 at posedge): acc[n], cap[n], clr_d, PE_result_out[n] all <= 0.
//     Reset overrides all other inputs; a reset mid-pass discards the partial sum.
//   - Accumulate: at posedge with PE_mac_enable==1 and PE_clear_acc==0:
//     acc[n] <= acc[n] + sext(PE_act_in[n]*PE_wet_in).
//     Full signed product is BW_ACT+BW_WET bits; the sum wraps two's-complement at BW_ACCU.
//   - Hold: PE_mac_enable==0 and PE_clear_acc==0 -> acc unchanged.
//   - Clear: at any posedge with PE_clear_acc==1 (regardless of PE_mac_enable):
//     acc[n] <= 0; the inputs on that cycle are NOT accumulated.
//   - Capture happens only on the first clear cycle (PE_clear_acc==1 && clr_d==0):
//     cap[n] <= acc[n].
//     clr_d <= PE_clear_acc every cycle.
//     Extra clear cycles only keep acc at 0 and leave cap unchanged.
//   - Output stage, every cycle: PE_result_out[n] <= sat(cap[n] >>> PE_res_shift_num).
//     >>> is an arithmetic (floor) shift.
//     A shift >= BW_ACCU yields 0 for non-negative cap and -1 for negative cap.
//     sat clamps to [-2^(BW_ACT-1), 2^(BW_ACT-1)-1], i.e. [-128, 127].
//     PE_res_shift_num is sampled in the output stage, so it is a quasi-static configuration input.
//   - Latency: clear sampled at posedge P0 -> result valid after posedge P1 (2 cycles).
//     The result stays stable until the next capture.
//   - First accumulate after clear: the cycle with PE_clear_acc==0 adds onto acc==0.
//   - Lanes are fully independent.
// TESTING
//   1. Reset: hold reset_n=1 for 2 clocks -> all PE_result_out==0; a subsequent clear with no MACs -> outputs stay 0.
//   2. Basic dot product: lane n act=n+1, wet=2, 150 MAC cycles, shift=0, then clear
//      -> lane0: 300 saturates to 127; lane n=-1 case below.
//      With shift=8 and act=100, wet=100, 150 cycles: sum 1,500,000 >>> 8 = 5859 -> 127 (saturated).
//   3. Exact shift/rounding: act=3, wet=5, 20 cycles (sum 300), shift=2 -> 75;
//      act=-3, wet=5, 20 cycles (sum -300), shift=2 -> -75; sum -301, shift=2 -> -76 (floor).
//   4. Negative saturation: act=-128, wet=127, 10 cycles, shift=4 -> -10160 -> -128.
//      Shift=40 on a negative sum -> -1.
//   5. Clear held 3 cycles, inputs unchanged during clear: result is the pre-clear sum, taken 2 cycles after clear rises.
//      Next pass starts from 0, with no leakage of the clear-cycle inputs.
//   6. Enable gating / mid-pass reset: drop PE_mac_enable for 5 cycles mid-pass -> those products are excluded;
//      assert reset mid-pass, then finish the pass -> only post-reset products are counted.

Source files
------------

// File: rtl/pe_array.sv
// pe_array: MAC_NUM signed multiply-accumulate lanes sharing one broadcast weight.
// Each lane accumulates act*wet at full precision. The first cycle of a clear
// request snapshots the running sum into a capture register and zeroes the
// accumulator. A registered output stage then requantises the captured value
// with an arithmetic right shift and saturates it to the activation width.
module pe_array #(
    parameter int MAC_NUM = 10,
    parameter int BW_ACT  = 8,
    parameter int BW_WET  = 8,
    parameter int BW_ACCU = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     PE_mac_enable,
    input  logic                     PE_clear_acc,
    input  logic signed [BW_ACT-1:0] PE_act_in [MAC_NUM],
    input  logic signed [BW_WET-1:0] PE_wet_in,
    input  logic [7:0]               PE_res_shift_num,
    output logic signed [BW_ACT-1:0] PE_result_out [MAC_NUM]
);

    localparam int BW_PROD = BW_ACT + BW_WET;

    // Any shift at or beyond the accumulator width leaves only sign bits.
    localparam logic [7:0] SHIFT_SAT = 8'(BW_ACCU);

    localparam logic signed [BW_ACCU-1:0] ACT_MAX = BW_ACCU'((2 ** (BW_ACT - 1)) - 1);
    localparam logic signed [BW_ACCU-1:0] ACT_MIN = BW_ACCU'(-(2 ** (BW_ACT - 1)));

    logic signed [BW_ACCU-1:0] acc_q     [MAC_NUM];
    logic signed [BW_ACCU-1:0] acc_d     [MAC_NUM];
    logic signed [BW_ACCU-1:0] cap_q     [MAC_NUM];
    logic signed [BW_ACCU-1:0] cap_d     [MAC_NUM];
    logic signed [BW_ACT-1:0]  res_q     [MAC_NUM];
    logic signed [BW_ACT-1:0]  res_d     [MAC_NUM];
    logic signed [BW_PROD-1:0] prod      [MAC_NUM];
    logic signed [BW_ACCU-1:0] prod_ext  [MAC_NUM];
    logic signed [BW_ACCU-1:0] shifted   [MAC_NUM];
    logic                      clr_dly_q;
    logic                      clr_dly_d;
    logic                      capture;

    // A capture only fires on the rising edge of the clear request, so a clear
    // held for several cycles does not overwrite the snapshot with zero.
    assign capture   = PE_clear_acc & ~clr_dly_q;
    assign clr_dly_d = PE_clear_acc;

    // Full-precision signed product per lane, sign-extended to accumulator width.
    always_comb begin
        for (int n = 0; n < MAC_NUM; n++) begin
            prod[n]     = BW_PROD'(PE_act_in[n]) * BW_PROD'(PE_wet_in);
            prod_ext[n] = {{(BW_ACCU - BW_PROD){prod[n][BW_PROD-1]}}, prod[n]};
        end
    end

    // Accumulator next state: clear wins over enable, and the sum wraps at BW_ACCU.
    always_comb begin
        for (int n = 0; n < MAC_NUM; n++) begin
            acc_d[n] = acc_q[n];
            if (PE_clear_acc) begin
                acc_d[n] = '0;
            end else if (PE_mac_enable) begin
                acc_d[n] = acc_q[n] + prod_ext[n];
            end
        end
    end

    // Capture register holds the finished pass until the next clear edge.
    always_comb begin
        for (int n = 0; n < MAC_NUM; n++) begin
            cap_d[n] = capture ? acc_q[n] : cap_q[n];
        end
    end

    // Requantise: floor shift (sign fill for oversized shifts), then saturate.
    always_comb begin
        for (int n = 0; n < MAC_NUM; n++) begin
            if (PE_res_shift_num >= SHIFT_SAT) begin
                shifted[n] = {BW_ACCU{cap_q[n][BW_ACCU-1]}};
            end else begin
                shifted[n] = cap_q[n] >>> PE_res_shift_num;
            end

            if (shifted[n] > ACT_MAX) begin
                res_d[n] = ACT_MAX[BW_ACT-1:0];
            end else if (shifted[n] < ACT_MIN) begin
                res_d[n] = ACT_MIN[BW_ACT-1:0];
            end else begin
                res_d[n] = shifted[n][BW_ACT-1:0];
            end
        end
    end

    // State registers; reset discards any partial sum and the previous result.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            clr_dly_q <= 1'b0;
            for (int n = 0; n < MAC_NUM; n++) begin
                acc_q[n] <= '0;
                cap_q[n] <= '0;
                res_q[n] <= '0;
            end
        end else begin
            clr_dly_q <= clr_dly_d;
            for (int n = 0; n < MAC_NUM; n++) begin
                acc_q[n] <= acc_d[n];
                cap_q[n] <= cap_d[n];
                res_q[n] <= res_d[n];
            end
        end
    end

    assign PE_result_out = res_q;

endmodule

// File: tb/tb_pe_array.sv
// Randomised and directed bench for pe_array against a pass-level sum model.
module tb_pe_array;

    localparam int N = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic              clr;
    logic signed [7:0] act [N];
    logic signed [7:0] wet;
    logic [7:0]        shift;
    logic signed [7:0] res [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: running dot product per lane, and the last completed pass.
    int sum_m [N];
    int cap_m [N];

    always #5 clk = ~clk;

    pe_array dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .PE_mac_enable    (en),
        .PE_clear_acc     (clr),
        .PE_act_in        (act),
        .PE_wet_in        (wet),
        .PE_res_shift_num (shift),
        .PE_result_out    (res)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // floor(v / 2^s), clamped to the signed 8-bit range
    function automatic int requant(input int v, input int s);
        longint q;
        longint p;
        if (s >= 32) begin
            q = (v < 0) ? -1 : 0;
        end else begin
            p = longint'(1) << s;
            if (v >= 0) q = v / p;
            else        q = -((p - 1 - longint'(v)) / p);
        end
        if (q > 127)  return 127;
        if (q < -128) return -128;
        return int'(q);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        for (int n = 0; n < N; n++)
            check_val($sformatf("%s lane%0d", tag, n), int'(res[n]), requant(cap_m[n], int'(shift)));
    endtask

    task automatic set_all(input int a, input int w);
        for (int n = 0; n < N; n++) act[n] = 8'(a);
        wet = 8'(w);
    endtask

    task automatic randomize_inputs;
        for (int n = 0; n < N; n++) act[n] = 8'($urandom);
        wet = 8'($urandom);
    endtask

    task automatic mac_cycle(input logic e);
        en  = e;
        clr = 1'b0;
        step();
        if (e)
            for (int n = 0; n < N; n++) sum_m[n] += int'(act[n]) * int'(wet);
    endtask

    task automatic mac_repeat(input int a, input int w, input int cycles);
        set_all(a, w);
        for (int i = 0; i < cycles; i++) mac_cycle(1'b1);
    endtask

    // Clear for ncyc cycles with garbage inputs; result must appear two cycles
    // after clear rises and persist through the remaining clear cycles.
    task automatic do_clear(input int ncyc);
        for (int n = 0; n < N; n++) begin
            cap_m[n] = sum_m[n];
            sum_m[n] = 0;
        end
        clr = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            en = 1'($urandom);
            randomize_inputs();
            step();
            if (i >= 1) check_outputs("clear");
        end
        clr = 1'b0;
        en  = 1'b0;
        if (ncyc == 1) begin
            step();
            check_outputs("clear");
        end
    endtask

    task automatic do_reset(input int ncyc);
        reset_n = 1'b1;
        en      = 1'b1;
        clr     = 1'($urandom);
        randomize_inputs();
        for (int i = 0; i < ncyc; i++) step();
        reset_n = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        for (int n = 0; n < N; n++) begin
            sum_m[n] = 0;
            cap_m[n] = 0;
        end
        check_outputs("reset");
    endtask

    initial begin
        reset_n = 1'b1;
        en      = 1'b0;
        clr     = 1'b0;
        shift   = 8'd0;
        set_all(0, 0);
        for (int n = 0; n < N; n++) begin
            sum_m[n] = 0;
            cap_m[n] = 0;
        end

        // Reset state, then a clear with no MACs keeps zero
        do_reset(2);
        do_clear(1);

        // Per-lane ramp, all lanes saturate positive
        for (int n = 0; n < N; n++) act[n] = 8'(n + 1);
        wet = 8'sd2;
        for (int i = 0; i < 150; i++) mac_cycle(1'b1);
        do_clear(1);
        check_val("ramp lane0", int'(res[0]), 127);
        check_val("ramp lane9", int'(res[9]), 127);

        shift = 8'd8;
        mac_repeat(100, 100, 150);
        do_clear(1);
        check_val("big shift8", int'(res[3]), 127);

        // Exact floor shifts
        shift = 8'd2;
        mac_repeat(3, 5, 20);
        do_clear(1);
        check_val("pos 300>>>2", int'(res[0]), 75);
        mac_repeat(-3, 5, 20);
        do_clear(2);
        check_val("neg -300>>>2", int'(res[0]), -75);
        mac_repeat(-3, 5, 20);
        mac_repeat(-1, 1, 1);
        do_clear(1);
        check_val("neg -301>>>2", int'(res[0]), -76);

        // Negative saturation and oversized shift
        shift = 8'd4;
        mac_repeat(-128, 127, 10);
        do_clear(1);
        check_val("neg sat", int'(res[5]), -128);
        shift = 8'd40;
        mac_repeat(-128, 127, 10);
        do_clear(1);
        check_val("shift40 neg", int'(res[5]), -1);

        // Clear held three cycles, then a clean pass from zero
        shift = 8'd0;
        mac_repeat(2, 3, 7);
        do_clear(3);
        check_val("clear3 sum", int'(res[1]), 42);
        mac_repeat(1, 5, 3);
        check_outputs("hold");
        do_clear(1);
        check_val("no leakage", int'(res[1]), 15);

        // Enable gating mid-pass
        mac_repeat(4, 2, 5);
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            mac_cycle(1'b0);
        end
        mac_repeat(4, 2, 5);
        do_clear(1);
        check_val("gated", int'(res[7]), 80);

        // Reset mid-pass: only post-reset products count
        mac_repeat(10, 10, 4);
        do_reset(1);
        mac_repeat(2, 2, 6);
        do_clear(1);
        check_val("mid reset", int'(res[2]), 24);

        // Randomised passes
        for (int p = 0; p < 40; p++) begin
            int r;
            int len;
            r = int'($urandom_range(0, 15));
            shift = (r < 14) ? 8'(r) : ((r == 14) ? 8'd40 : 8'd255);
            len = int'($urandom_range(1, 40));
            wet = 8'($urandom);
            for (int i = 0; i < len; i++) begin
                for (int n = 0; n < N; n++) act[n] = 8'($urandom);
                if ($urandom_range(0, 3) == 0) wet = 8'($urandom);
                mac_cycle($urandom_range(0, 3) != 0);
                if (i == len / 2 && $urandom_range(0, 7) == 0) do_reset(1);
            end
            check_outputs("hold");
            do_clear(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
